// File: rtl/sm_frame_acc.sv
// sm_frame_acc: collects n handshaked input beats into one summed output word
// per frame, with valid/ready on both sides, selectable wrap or saturate on
// overflow, and a sticky per-frame overflow flag.
module sm_frame_acc #(
    parameter int IW   = 8,
    parameter int OW   = 12,
    parameter int MAXN = 16,
    parameter int SAT  = 0,
    parameter int CNTW = $clog2(MAXN + 1)
) (
    input  logic            clk,
    input  logic            rst,      // asynchronous, active-low
    input  logic [CNTW-1:0] cfg_n,
    input  logic            i_dval,
    output logic            i_rdy,
    input  logic [IW-1:0]   i,
    output logic            o_dval,
    input  logic            o_rdy,
    output logic [OW-1:0]   o,
    output logic            o_ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } state_e;

    localparam logic [CNTW-1:0] MAXN_C = CNTW'(MAXN);

    state_e          state_q;
    logic [OW-1:0]   acc_q;
    logic [CNTW-1:0] cnt_q;
    logic [CNTW-1:0] n_q;
    logic            ovf_q;
    logic            i_rdy_q;
    logic            o_dval_q;
    logic [OW-1:0]   o_q;
    logic            o_ovf_q;

    logic            beat;
    logic [CNTW-1:0] n_cfg;
    logic [OW-1:0]   acc_base;
    logic [OW:0]     sum_w;
    logic            carry;
    logic [OW-1:0]   acc_d;
    logic            ovf_d;
    logic [CNTW-1:0] cnt_d;
    logic [CNTW-1:0] n_d;
    logic            last;

    // Next-beat datapath: a first beat starts from zero with fresh frame
    // length and overflow flag, later beats build on the held state.
    always_comb begin
        beat  = i_dval && i_rdy_q;
        n_cfg = cfg_n;
        if (cfg_n == '0) begin
            n_cfg = CNTW'(1);
        end else if (cfg_n > MAXN_C) begin
            n_cfg = MAXN_C;
        end

        acc_base = (state_q == IDLE) ? '0 : acc_q;
        sum_w    = {1'b0, acc_base} + (OW + 1)'(i);
        carry    = sum_w[OW];
        acc_d    = (carry && (SAT != 0)) ? '1 : sum_w[OW-1:0];
        ovf_d    = ((state_q == IDLE) ? 1'b0 : ovf_q) | carry;
        cnt_d    = (state_q == IDLE) ? CNTW'(1) : cnt_q + 1'b1;
        n_d      = (state_q == IDLE) ? n_cfg : n_q;
        last     = (cnt_d == n_d);
    end

    // Frame FSM with all state and outputs registered; accumulator is only
    // written on an accepted beat, so data under a low valid never reaches it.
    // NOTE: the reset branch covers every register, including i_rdy_q, so the
    // input side reads not-ready for as long as rst is held low; all updates
    // are non-blocking so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            n_q      <= '0;
            ovf_q    <= 1'b0;
            i_rdy_q  <= 1'b0;
            o_dval_q <= 1'b0;
            o_q      <= '0;
            o_ovf_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, ACC: begin
                    i_rdy_q <= 1'b1;
                    if (beat) begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_d;
                        n_q   <= n_d;
                        ovf_q <= ovf_d;
                        if (last) begin
                            state_q  <= OUT;
                            i_rdy_q  <= 1'b0;
                            o_dval_q <= 1'b1;
                            o_q      <= acc_d;
                            o_ovf_q  <= ovf_d;
                        end else begin
                            state_q <= ACC;
                        end
                    end
                end
                OUT: begin
                    if (o_rdy) begin
                        state_q  <= IDLE;
                        o_dval_q <= 1'b0;
                        i_rdy_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    i_rdy_q  <= 1'b0;
                    o_dval_q <= 1'b0;
                end
            endcase
        end
    end

    assign i_rdy  = i_rdy_q;
    assign o_dval = o_dval_q;
    assign o      = o_q;
    assign o_ovf  = o_ovf_q;

endmodule

// File: tb/tb_sm_frame_acc.sv
// Testbench for sm_frame_acc: three instances share one input stream
// (12-bit wrap, 10-bit wrap, 10-bit saturate) so overflow behaviour of both
// modes is compared against hand-computed sums on the same frames.
module tb_sm_frame_acc;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] cfg_n = '0;
    logic       i_dval = 1'b0;
    logic [7:0] din = '0;
    logic       o_rdy = 1'b1;

    logic        i_rdy0, o_dval0, ovf0;
    logic [11:0] o0;
    logic        i_rdy1, o_dval1, ovf1;
    logic [9:0]  o1;
    logic        i_rdy2, o_dval2, ovf2;
    logic [9:0]  o2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sm_frame_acc #(.IW(8), .OW(12), .MAXN(16), .SAT(0)) u_main (
        .clk(clk), .rst(rst), .cfg_n(cfg_n), .i_dval(i_dval), .i_rdy(i_rdy0),
        .i(din), .o_dval(o_dval0), .o_rdy(o_rdy), .o(o0), .o_ovf(ovf0)
    );
    sm_frame_acc #(.IW(8), .OW(10), .MAXN(16), .SAT(0)) u_wrap (
        .clk(clk), .rst(rst), .cfg_n(cfg_n), .i_dval(i_dval), .i_rdy(i_rdy1),
        .i(din), .o_dval(o_dval1), .o_rdy(o_rdy), .o(o1), .o_ovf(ovf1)
    );
    sm_frame_acc #(.IW(8), .OW(10), .MAXN(16), .SAT(1)) u_sat (
        .clk(clk), .rst(rst), .cfg_n(cfg_n), .i_dval(i_dval), .i_rdy(i_rdy2),
        .i(din), .o_dval(o_dval2), .o_rdy(o_rdy), .o(o2), .o_ovf(ovf2)
    );

    typedef struct packed {
        logic [4:0]        cfg;
        logic [4:0]        nb;
        logic [15:0][7:0]  data;
        logic [11:0]       e0;
        logic              e0v;
        logic [9:0]        e1;
        logic              e1v;
        logic [9:0]        e2;
        logic              e2v;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one beat and wait (bounded) for the handshake edge.
    task automatic send_beat(input logic [4:0] c, input logic [7:0] d);
        int   budget;
        logic hs;
        cfg_n  = c;
        din    = d;
        i_dval = 1'b1;
        budget = 0;
        do begin
            hs = i_rdy0;
            step();
            budget++;
        end while (!hs && budget < 20);
        if (!hs) check("beat_handshake", {31'd0, hs}, 1);
        i_dval = 1'b0;
    endtask

    // Called one cycle after the last beat: frame must be presented, then
    // transfer with o_rdy=1 and leave o_dval low the following cycle.
    task automatic expect_frame(input string tag,
                                input logic [11:0] e0, input logic e0v,
                                input logic [9:0] e1, input logic e1v,
                                input logic [9:0] e2, input logic e2v);
        check({tag, "_dval"}, {29'd0, o_dval2, o_dval1, o_dval0}, 32'd7);
        check({tag, "_o12"}, {20'd0, o0}, {20'd0, e0});
        check({tag, "_ovf12"}, {31'd0, ovf0}, {31'd0, e0v});
        check({tag, "_o10w"}, {22'd0, o1}, {22'd0, e1});
        check({tag, "_ovf10w"}, {31'd0, ovf1}, {31'd0, e1v});
        check({tag, "_o10s"}, {22'd0, o2}, {22'd0, e2});
        check({tag, "_ovf10s"}, {31'd0, ovf2}, {31'd0, e2v});
        check({tag, "_irdy_out"}, {31'd0, i_rdy0}, 0);
        o_rdy = 1'b1;
        step();
        check({tag, "_dval_drop"}, {31'd0, o_dval0}, 0);
        check({tag, "_irdy_back"}, {31'd0, i_rdy0}, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Table: cfg, beats, data, then expected {12w, 10w, 10s} sum/ovf.
        for (int v = 0; v < 8; v++) vecs[v] = '0;
        vecs[0].cfg = 5'd4;  vecs[0].nb = 5'd4;
        vecs[0].data[0] = 8'd10; vecs[0].data[1] = 8'd20;
        vecs[0].data[2] = 8'd30; vecs[0].data[3] = 8'd40;
        vecs[0].e0 = 12'd100; vecs[0].e1 = 10'd100; vecs[0].e2 = 10'd100;
        vecs[1].cfg = 5'd0;  vecs[1].nb = 5'd1; vecs[1].data[0] = 8'd7;
        vecs[1].e0 = 12'd7; vecs[1].e1 = 10'd7; vecs[1].e2 = 10'd7;
        vecs[2].cfg = 5'd1;  vecs[2].nb = 5'd1; vecs[2].data[0] = 8'd255;
        vecs[2].e0 = 12'd255; vecs[2].e1 = 10'd255; vecs[2].e2 = 10'd255;
        vecs[3].cfg = 5'd16; vecs[3].nb = 5'd16; vecs[3].data = '1;
        vecs[3].e0 = 12'd4080; vecs[3].e1 = 10'd1008; vecs[3].e1v = 1'b1;
        vecs[3].e2 = 10'd1023; vecs[3].e2v = 1'b1;
        vecs[4].cfg = 5'd20; vecs[4].nb = 5'd16; vecs[4].data = {16{8'd1}};
        vecs[4].e0 = 12'd16; vecs[4].e1 = 10'd16; vecs[4].e2 = 10'd16;
        vecs[5].cfg = 5'd3;  vecs[5].nb = 5'd3;
        for (int b = 0; b < 3; b++) vecs[5].data[b] = 8'd200;
        vecs[5].e0 = 12'd600; vecs[5].e1 = 10'd600; vecs[5].e2 = 10'd600;
        vecs[6].cfg = 5'd5;  vecs[6].nb = 5'd5;
        for (int b = 0; b < 5; b++) vecs[6].data[b] = 8'd250;
        vecs[6].e0 = 12'd1250; vecs[6].e1 = 10'd226; vecs[6].e1v = 1'b1;
        vecs[6].e2 = 10'd1023; vecs[6].e2v = 1'b1;
        vecs[7].cfg = 5'd2;  vecs[7].nb = 5'd2;
        vecs[7].e0 = 12'd0; vecs[7].e1 = 10'd0; vecs[7].e2 = 10'd0;

        // Reset held with i_dval asserted.
        i_dval = 1'b1;
        din    = 8'd55;
        cfg_n  = 5'd1;
        repeat (5) begin
            step();
            check("rst_dval", {31'd0, o_dval0}, 0);
            check("rst_irdy", {31'd0, i_rdy0}, 0);
        end
        check("rst_o", {20'd0, o0}, 0);
        check("rst_ovf", {31'd0, ovf0}, 0);
        i_dval = 1'b0;
        rst    = 1'b1;
        step();
        check("rst_release_irdy", {31'd0, i_rdy0}, 1);
        check("rst_release_dval", {31'd0, o_dval0}, 0);

        // Table-driven frames, back-to-back beats, o_rdy held high.
        for (int v = 0; v < 8; v++) begin
            o_rdy = 1'b1;
            for (int b = 0; b < int'(vecs[v].nb); b++) begin
                send_beat(vecs[v].cfg, vecs[v].data[b]);
                if (b < int'(vecs[v].nb) - 1)
                    check($sformatf("vec%0d_no_early_dval", v), {31'd0, o_dval0}, 0);
            end
            expect_frame($sformatf("vec%0d", v), vecs[v].e0, vecs[v].e0v,
                         vecs[v].e1, vecs[v].e1v, vecs[v].e2, vecs[v].e2v);
        end

        // Bubbles between beats and cfg_n changed to 2 after the first beat.
        begin
            logic [7:0] gd [4];
            gd[0] = 8'd10; gd[1] = 8'd20; gd[2] = 8'd30; gd[3] = 8'd40;
            for (int k = 0; k < 4; k++) begin
                repeat ($urandom_range(0, 3)) step();
                send_beat((k == 0) ? 5'd4 : 5'd2, gd[k]);
                if (k < 3) check("gap_no_early_dval", {31'd0, o_dval0}, 0);
            end
            expect_frame("gap", 12'd100, 1'b0, 10'd100, 1'b0, 10'd100, 1'b0);
        end

        // Output backpressure: frame held stable, no beats accepted.
        o_rdy = 1'b0;
        send_beat(5'd2, 8'd1);
        send_beat(5'd2, 8'd2);
        i_dval = 1'b1;
        din    = 8'd99;
        repeat (5) begin
            check("bp_dval", {31'd0, o_dval0}, 1);
            check("bp_o", {20'd0, o0}, 3);
            check("bp_irdy", {31'd0, i_rdy0}, 0);
            step();
        end
        i_dval = 1'b0;
        expect_frame("bp", 12'd3, 1'b0, 10'd3, 1'b0, 10'd3, 1'b0);
        send_beat(5'd1, 8'd5);
        expect_frame("post_bp", 12'd5, 1'b0, 10'd5, 1'b0, 10'd5, 1'b0);

        // Reset after 2 of 4 beats: partial frame dropped, next frame clean.
        send_beat(5'd4, 8'd50);
        send_beat(5'd4, 8'd60);
        rst = 1'b0;
        #1;
        check("midrst_irdy", {31'd0, i_rdy0}, 0);
        check("midrst_dval", {31'd0, o_dval0}, 0);
        check("midrst_o", {20'd0, o0}, 0);
        repeat (2) step();
        rst = 1'b1;
        step();
        check("midrst_release_dval", {31'd0, o_dval0}, 0);
        check("midrst_release_irdy", {31'd0, i_rdy0}, 1);
        for (int k = 0; k < 4; k++) begin
            send_beat(5'd4, 8'd1);
            if (k < 3) check("midrst_no_early_dval", {31'd0, o_dval0}, 0);
        end
        expect_frame("midrst_next", 12'd4, 1'b0, 10'd4, 1'b0, 10'd4, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sm_frame_acc.md
Name: sm_frame_acc

Overview:
- Parametrised successor to the single-channel valid-in/valid-out state-machine DUT.
- Accumulates a configurable number of input beats into one output word per frame.
- Adds ready backpressure on both sides, a selectable wrap/saturate overflow mode and an overflow flag.
- Sits in the protocol-verification sim as the next DUT driven by valid/ready bus masters and checked by slave monitors.

Parameters:
- IW, 8, input data width (bits).
- OW, 12, output/accumulator width (bits); OW >= IW required.
- MAXN, 16, maximum beats per frame.
- SAT, 0, overflow mode: 0 = wrap modulo 2^OW, 1 = clamp to 2^OW-1.
- CNTW, $clog2(MAXN+1), derived width of beat counter and cfg_n.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- cfg_n  in  CNTW  beats per frame; sampled only at first beat of a frame.
- i_dval  in  1  input beat valid.
- i_rdy  out  1  input ready; beat transfers when i_dval && i_rdy at a clk edge.
- i  in  IW  input beat data, unsigned.
- o_dval  out  1  output frame valid.
- o_rdy  in  1  output ready; frame transfers when o_dval && o_rdy.
- o  out  OW  frame sum.
- o_ovf  out  1  overflow occurred in this frame.

Behaviour:
- States: IDLE, ACC, OUT. Reset (rst low, async) -> IDLE.
- Reset values: acc=0, cnt=0, o=0, o_ovf=0, o_dval=0; i_rdy forced 0 while rst is low.
- i_rdy = 1 in IDLE and ACC, 0 in OUT. o_dval = 1 only in OUT.
- IDLE, beat accepted:
  - Latch n = cfg_n; cfg_n==0 treated as 1; cfg_n>MAXN clamped to MAXN.
  - acc = zero-extended i; cnt = 1; ovf = 0.
  - Go to OUT if n==1, else ACC.
- ACC, beat accepted:
  - acc = acc + i (OW-bit result, carry detected); cnt++.
  - Go to OUT when cnt reaches n.
  - No beat accepted: hold all state.
- Overflow:
  - On carry: ovf=1 (sticky for the frame).
  - SAT=0: acc keeps low OW bits.
  - SAT=1: acc = 2^OW-1; later adds keep it clamped.
- OUT:
  - o = acc, o_ovf = ovf; both stable while o_rdy=0.
  - On o_rdy=1: frame transfers, go to IDLE next cycle; o_dval drops that cycle.
- Latency:
  - o_dval rises in the cycle after the last beat handshake.
  - Minimum frame period: n+1 cycles. No input accepted in OUT.
- Only handshaked beats count; i_dval gaps (bubbles) insert idle cycles without effect.
- cfg_n changes mid-frame are ignored until the next IDLE.
- Reset mid-frame: partial frame discarded, no output produced; next frame starts clean.
- i/o_rdy values are don't-care when their valid is low; no X propagation into acc.

Test Plan:
- Reset: hold rst low 5 cycles with i_dval=1 -> o_dval=0, i_rdy=0, o=0, o_ovf=0; after rst high, i_rdy=1 at next edge.
- cfg_n=4, back-to-back beats 10,20,30,40, o_rdy=1 -> o=100, o_ovf=0, o_dval high exactly one cycle, starting the cycle after beat 40.
- Same frame with random 0-3 cycle i_dval gaps and cfg_n toggled to 2 mid-frame -> still o=100 after 4 beats.
- Backpressure: frame 1,2 (cfg_n=2), o_rdy=0 for 5 cycles -> o=3 and o_dval held stable, i_rdy=0 throughout; o_rdy=1 -> back in IDLE, i_rdy=1 next cycle.
- Overflow with OW=10, cfg_n=16, all beats 255: SAT=0 -> o=1008, o_ovf=1; SAT=1 -> o=1023, o_ovf=1.
- Edge cases:
  - cfg_n=0, single beat 7 -> o=7 after 1 beat.
  - cfg_n=20 with MAXN=16 -> frame ends after 16 beats.
  - rst pulsed low after 2 of 4 beats -> no o_dval; next frame 1,1,1,1 -> o=4.
